// File: rtl/bvh_prim_dispatch.sv
// Leaf-range dispatcher: queues non-empty child ranges from BVH traversal and
// expands them into a valid/ready stream of primitive indices.
module bvh_prim_dispatch #(
   parameter int IDX_W = 10,
   parameter int NUM_W = 4,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic [IDX_W-1:0] start_prim0,
   input  logic [IDX_W-1:0] start_prim1,
   input  logic [NUM_W-1:0] num_prim0,
   input  logic [NUM_W-1:0] num_prim1,
   input  logic             bvh_finished,
   output logic             hold,
   output logic             prim_valid,
   output logic [IDX_W-1:0] prim_index,
   output logic             prim_last,
   input  logic             prim_ready,
   output logic             done,
   output logic             overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] MARGIN_C = CW'(4);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
   localparam logic [NUM_W-1:0] NUM_ONE  = NUM_W'(1);

   logic [IDX_W-1:0] fifo_idx_r [DEPTH];
   logic [NUM_W-1:0] fifo_num_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [IDX_W-1:0] cur_index_r;
   logic [NUM_W-1:0] remaining_r;
   logic             overflow_r;
   logic             done_r;

   logic             req0_s;
   logic             req1_s;
   logic             wr0_s;
   logic             wr1_s;
   logic             drop_s;
   logic             hs_s;
   logic             load_s;
   logic [PW-1:0]    wr1_ptr_s;
   logic [CW-1:0]    count_nxt_s;
   logic             done_nxt_s;

   // Write admission, drop detection, handshake and reload decisions.
   always_comb begin
      req0_s      = (num_prim0 != NUM_ZERO);
      req1_s      = (num_prim1 != NUM_ZERO);
      // Fullness is judged on the occupancy before this edge; a same-cycle pop
      // does not make room for an incoming range.
      wr0_s       = req0_s && (count_r < DEPTH_C);
      wr1_s       = req1_s && ((count_r + CW'(wr0_s)) < DEPTH_C);
      drop_s      = (req0_s && !wr0_s) || (req1_s && !wr1_s);
      wr1_ptr_s   = wr_ptr_r + PW'(wr0_s);
      hs_s        = (remaining_r != NUM_ZERO) && prim_ready;
      load_s      = (count_r != CNT_ZERO) &&
                    ((remaining_r == NUM_ZERO) || ((remaining_r == NUM_ONE) && hs_s));
      count_nxt_s = count_r + CW'(wr0_s) + CW'(wr1_s) - CW'(load_s);
      done_nxt_s  = bvh_finished && (count_r == CNT_ZERO) && (remaining_r == NUM_ZERO) &&
                    !req0_s && !req1_s;
   end

   // Range storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (!restart) begin
         if (wr0_s) begin
            fifo_idx_r[wr_ptr_r] <= start_prim0;
            fifo_num_r[wr_ptr_r] <= num_prim0;
         end
         if (wr1_s) begin
            fifo_idx_r[wr1_ptr_s] <= start_prim1;
            fifo_num_r[wr1_ptr_s] <= num_prim1;
         end
      end
   end

   // Pointers, occupancy, active range and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         count_r     <= CNT_ZERO;
         cur_index_r <= {IDX_W{1'b0}};
         remaining_r <= NUM_ZERO;
         overflow_r  <= 1'b0;
         done_r      <= 1'b0;
      end else if (restart) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         count_r     <= CNT_ZERO;
         cur_index_r <= {IDX_W{1'b0}};
         remaining_r <= NUM_ZERO;
         overflow_r  <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_r + PW'(wr0_s) + PW'(wr1_s);
         rd_ptr_r   <= rd_ptr_r + PW'(load_s);
         count_r    <= count_nxt_s;
         overflow_r <= overflow_r | drop_s;
         done_r     <= done_nxt_s;
         // Reloading on the last handshake of a range keeps the stream bubble-free.
         if (load_s) begin
            cur_index_r <= fifo_idx_r[rd_ptr_r];
            remaining_r <= fifo_num_r[rd_ptr_r];
         end else if (hs_s) begin
            cur_index_r <= cur_index_r + IDX_W'(hs_s);
            remaining_r <= remaining_r - NUM_W'(hs_s);
         end
      end
   end

   assign hold       = ((DEPTH_C - count_r) < MARGIN_C);
   assign prim_valid = (remaining_r != NUM_ZERO);
   assign prim_index = cur_index_r;
   assign prim_last  = (remaining_r == NUM_ONE);
   assign done       = done_r;
   assign overflow   = overflow_r;
endmodule
